// File: rtl/prog_mem.sv
// prog_mem: loadable 256x8 program store; presents mem[PC] to the processor while run=1, else NOP_OPCODE.
// Latency: zero-cycle combinational fetch; run rises the cycle after done. Optional PROG_MEM_CHECKSUM_EN adds chk.
// Backpressure: ld_ready is high only in LOAD; ld_valid low stalls the session with no state change.
module prog_mem #(
  parameter logic [7:0] NOP_OPCODE = 8'h00,
  parameter int         DEPTH      = 256
) (
  input  logic       clk,
  input  logic       CLB,
  input  logic [7:0] PC,
  output logic [7:0] INST,
  input  logic       load_start,
  input  logic [7:0] load_len,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  output logic       ld_ready,
  output logic       busy,
  output logic       done,
`ifdef PROG_MEM_CHECKSUM_EN
  output logic [7:0] chk,
`endif
  output logic       run
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t     state, stateNext;
  logic [7:0] wrAddr;
  logic [8:0] remaining;
  logic       loaded, loadedNext;
  logic       runQ;
  logic       accept;
  logic [7:0] mem [DEPTH];

  assign ld_ready = (state == LOAD);
  assign busy     = (state == LOAD);
  assign done     = (state == DONE);
  assign accept   = ld_valid & ld_ready;
  assign run      = runQ;
  assign INST     = runQ ? mem[PC] : NOP_OPCODE;

  always_comb begin
    stateNext  = state;
    loadedNext = loaded;
    case (state)
      IDLE: if (load_start) begin
        stateNext  = LOAD;
        loadedNext = 1'b0;
      end
      LOAD: if (accept && remaining == 9'd1) stateNext = DONE;
      DONE: begin
        stateNext  = IDLE;
        loadedNext = 1'b1;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) begin
      state     <= IDLE;
      wrAddr    <= 8'h00;
      remaining <= 9'd0;
      loaded    <= 1'b0;
      runQ      <= 1'b0;
    end else begin
      state  <= stateNext;
      loaded <= loadedNext;
      // Registered from next-state so run drops as soon as a reload starts.
      runQ   <= loadedNext & (stateNext == IDLE);
      if (state == IDLE && load_start) begin
        wrAddr    <= 8'h00;
        remaining <= {(load_len == 8'h00), load_len};
      end else if (accept) begin
        wrAddr    <= wrAddr + 8'h01;
        remaining <= remaining - 9'd1;
      end
    end
  end

  // Program words survive reset; only the write port is clocked here.
  always_ff @(posedge clk) begin
    if (accept) mem[wrAddr] <= ld_data;
  end

`ifdef PROG_MEM_CHECKSUM_EN
  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) begin
      chk <= 8'h00;
    end else if (state == IDLE && load_start) begin
      chk <= 8'h00;
    end else if (accept) begin
      chk <= chk ^ ld_data;
    end
  end
`endif

endmodule

// File: tb/tb_prog_mem.sv
// Directed self-checking bench for prog_mem: reset, short/full/gapped loads, mid-load abort, optional checksum.
module tb_prog_mem;
  localparam logic [7:0] NOP = 8'h00;

  logic       clk = 1'b0;
  logic       CLB;
  logic [7:0] PC;
  logic [7:0] INST;
  logic       load_start;
  logic [7:0] load_len;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic       busy;
  logic       done;
  logic       run;
`ifdef PROG_MEM_CHECKSUM_EN
  logic [7:0] chk;
`endif

  int tests = 0;
  int errors = 0;
  int doneCnt = 0;
  int readyCnt = 0;
  logic [7:0] ldBytes [256];

  prog_mem #(.NOP_OPCODE(NOP), .DEPTH(256)) dut (
    .clk(clk), .CLB(CLB), .PC(PC), .INST(INST),
    .load_start(load_start), .load_len(load_len),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .busy(busy), .done(done),
`ifdef PROG_MEM_CHECKSUM_EN
    .chk(chk),
`endif
    .run(run)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) doneCnt = doneCnt + 1;
    if (ld_ready) readyCnt = readyCnt + 1;
  end

  // Runs a full session of n bytes from ldBytes with gap idle cycles before each byte.
  task automatic doLoad(input int n, input int gap);
    logic busyOk;
    busyOk = 1'b1;
    @(negedge clk);
    load_start = 1'b1;
    load_len   = n[7:0];
    @(negedge clk);
    load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) begin
        ld_valid = 1'b0;
        if (busy !== 1'b1 || ld_ready !== 1'b1 || run !== 1'b0) busyOk = 1'b0;
        @(negedge clk);
      end
      if (busy !== 1'b1 || ld_ready !== 1'b1 || done !== 1'b0) busyOk = 1'b0;
      ld_valid = 1'b1;
      ld_data  = ldBytes[i];
      @(negedge clk);
    end
    ld_valid = 1'b0;
    tests++;
    if (busyOk !== 1'b1) begin errors++; $display("FAIL load_busy n=%0d: busy/ready dropped or done early, required held", n); end
    tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL load_done n=%0d: done=%b busy=%b, required 1/0", n, done, busy); end
    @(negedge clk);
    tests++;
    if (run !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL load_run n=%0d: run=%b done=%b, required 1/0", n, run, done); end
  endtask

  task automatic test_reset();
    CLB = 1'b0; PC = 8'h00; load_start = 1'b0; load_len = 8'h00; ld_valid = 1'b0; ld_data = 8'h00;
    #12;
    tests++;
    if (run !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ld_ready !== 1'b0) begin
      errors++; $display("FAIL reset_outs: run=%b busy=%b done=%b rdy=%b, required 0", run, busy, done, ld_ready);
    end
    CLB = 1'b1;
    @(negedge clk);
    PC = 8'h37; #1;
    tests++;
    if (INST !== NOP || run !== 1'b0) begin errors++; $display("FAIL preload_nop: INST=%h run=%b, required %h/0", INST, run, NOP); end
  endtask

  task automatic test_basic();
    int d0, r0;
    d0 = doneCnt; r0 = readyCnt;
    ldBytes[0] = 8'h1A; ldBytes[1] = 8'h2B; ldBytes[2] = 8'h3C;
    @(negedge clk);
    load_start = 1'b1; load_len = 8'd3;
    @(negedge clk);
    load_start = 1'b0; PC = 8'h01; #1;
    tests++;
    if (INST !== NOP || run !== 1'b0) begin errors++; $display("FAIL load_nop: INST=%h run=%b, required %h/0", INST, run, NOP); end
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = ldBytes[i];
      @(negedge clk);
    end
    ld_valid = 1'b0;
    tests++;
    if (done !== 1'b1) begin errors++; $display("FAIL basic_done: done=%b, required 1", done); end
    @(negedge clk);
    #1;
    tests++;
    if (run !== 1'b1 || INST !== 8'h2B) begin errors++; $display("FAIL basic_fetch: run=%b INST=%h, required 1/2b", run, INST); end
    tests++;
    if (readyCnt - r0 !== 3 || doneCnt - d0 !== 1) begin
      errors++; $display("FAIL basic_counts: ready=%0d done=%0d, required 3/1", readyCnt - r0, doneCnt - d0);
    end
  endtask

  task automatic test_full256();
    int d0;
    d0 = doneCnt;
    for (int i = 0; i < 256; i++) ldBytes[i] = i[7:0];
    doLoad(256, 0);
    PC = 8'hFF; #1;
    tests++;
    if (INST !== 8'hFF) begin errors++; $display("FAIL full_ff: INST=%h, required ff", INST); end
    PC = 8'h01; #1;
    tests++;
    if (INST !== 8'h01) begin errors++; $display("FAIL full_01: INST=%h, required 01", INST); end
    tests++;
    if (doneCnt - d0 !== 1) begin errors++; $display("FAIL full_donecnt: %0d, required 1", doneCnt - d0); end
  endtask

  task automatic test_gaps();
    int d0;
    d0 = doneCnt;
    ldBytes[0] = 8'h55; ldBytes[1] = 8'h66;
    doLoad(2, 5);
    PC = 8'h00; #1;
    tests++;
    if (INST !== 8'h55) begin errors++; $display("FAIL gap_w0: INST=%h, required 55", INST); end
    PC = 8'h01; #1;
    tests++;
    if (INST !== 8'h66) begin errors++; $display("FAIL gap_w1: INST=%h, required 66", INST); end
    PC = 8'h02; #1;
    tests++;
    if (INST !== 8'h02) begin errors++; $display("FAIL gap_retain: INST=%h, required 02", INST); end
    tests++;
    if (doneCnt - d0 !== 1) begin errors++; $display("FAIL gap_donecnt: %0d, required 1", doneCnt - d0); end
  endtask

  task automatic test_abort();
    @(negedge clk);
    load_start = 1'b1; load_len = 8'd4;
    @(negedge clk);
    load_start = 1'b0;
    tests++;
    if (run !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL reload_drop: run=%b busy=%b, required 0/1", run, busy); end
    ld_valid = 1'b1; ld_data = 8'hAA;
    @(negedge clk);
    ld_valid = 1'b0;
    #2 CLB = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || ld_ready !== 1'b0 || run !== 1'b0 || INST !== NOP) begin
      errors++; $display("FAIL abort: busy=%b rdy=%b run=%b INST=%h, required 0/0/0/%h", busy, ld_ready, run, INST, NOP);
    end
    #2 CLB = 1'b1;
    @(negedge clk);
    tests++;
    if (run !== 1'b0) begin errors++; $display("FAIL abort_run: run=%b, required 0", run); end
    ldBytes[0] = 8'h11; ldBytes[1] = 8'h22; ldBytes[2] = 8'h33; ldBytes[3] = 8'h44;
    doLoad(4, 0);
    PC = 8'h00; #1;
    tests++;
    if (INST !== 8'h11) begin errors++; $display("FAIL abort_new0: INST=%h, required 11", INST); end
    PC = 8'h03; #1;
    tests++;
    if (INST !== 8'h44) begin errors++; $display("FAIL abort_new3: INST=%h, required 44", INST); end
  endtask

`ifdef PROG_MEM_CHECKSUM_EN
  task automatic test_checksum();
    ldBytes[0] = 8'hF0; ldBytes[1] = 8'h0F; ldBytes[2] = 8'hAA;
    doLoad(3, 1);
    tests++;
    if (chk !== 8'h55) begin errors++; $display("FAIL checksum: chk=%h, required 55", chk); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_full256();
    test_gaps();
    test_abort();
`ifdef PROG_MEM_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/prog_mem.md
PROG_MEM -- requirements
Module: prog_mem

Interface
REQ-001 Parameter NOP_OPCODE, default 8'h00, instruction byte driven on INST whenever the processor is not running.
REQ-002 Parameter DEPTH, default 256, number of 8-bit program words; fixed at 256 so PC addresses every word.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 CLB  input  1  asynchronous, active-low clear.
REQ-005 PC  input  8  fetch address from the processor program counter.
REQ-006 INST  output  8  instruction byte presented to the processor IR.
REQ-007 load_start  input  1  single-cycle request to begin a program load session.
REQ-008 load_len  input  8  byte count for the session, sampled with load_start; 8'h00 encodes 256.
REQ-009 ld_valid  input  1  loader byte valid.
REQ-010 ld_data  input  8  loader byte.
REQ-011 ld_ready  output  1  block accepts ld_data this cycle.
REQ-012 busy  output  1  load session in progress.
REQ-013 done  output  1  one-cycle pulse when the final byte has been written.
REQ-014 run  output  1  program present and no load in progress; the processor top gates its CLB with run.

Function
REQ-015 FSM states: IDLE, LOAD, DONE.
REQ-016 IDLE: ld_ready=0, busy=0; load_start=1 -> LOAD, wr_addr<=0, remaining<=load_len (0 -> 256), loaded<=0.
REQ-017 LOAD: ld_ready=1, busy=1; on ld_valid&ld_ready: mem[wr_addr]<=ld_data, wr_addr<=wr_addr+1, remaining<=remaining-1.
REQ-018 LOAD: acceptance of the byte with remaining==1 -> DONE in the following cycle; no further bytes are accepted.
REQ-019 LOAD: ld_valid=0 stalls the session indefinitely with no state change.
REQ-020 LOAD/DONE: load_start is ignored.
REQ-021 DONE: done=1 and busy=0 for exactly one cycle, loaded<=1, then -> IDLE.
REQ-022 wr_addr is 8 bits; with a 256-byte load it wraps 8'hFF -> 8'h00 after the final write, which is harmless.
REQ-023 Words not written in a session retain their previous contents.
REQ-024 run = loaded & (state==IDLE); registered, so it rises the cycle after done.
REQ-025 INST = mem[PC] combinationally when run=1; otherwise INST = NOP_OPCODE, with zero cycles of read latency.
REQ-026 load_start in IDLE while run=1 drops run the next cycle; the processor is held until the new load completes.

Reset
REQ-027 CLB=0 asynchronously forces state=IDLE, wr_addr=0, remaining=0, loaded=0, run=0, done=0, busy=0, ld_ready=0; INST=NOP_OPCODE.
REQ-028 CLB asserted mid-load aborts the session; bytes already written stay in memory but run stays 0 until a full new load completes.
REQ-029 Memory array contents are not cleared by reset.

Configuration
REQ-030 Macro PROG_MEM_CHECKSUM_EN: when defined, add output chk[7:0], cleared on load_start and by CLB, XORed with every accepted ld_data, and held stable from done until the next load_start.
REQ-031 Without PROG_MEM_CHECKSUM_EN: no chk port and no checksum logic.

Verification
REQ-032 Reset, then load_len=3 with bytes 8'h1A,8'h2B,8'h3C and ld_valid held high -> ld_ready high 3 cycles, done pulses once, run=1; PC=1 -> INST=8'h2B.
REQ-033 Before any load, and during LOAD, any PC -> INST=NOP_OPCODE, run=0.
REQ-034 load_len=8'h00 with 256 bytes data=address -> done after the 256th byte only; PC=8'hFF -> INST=8'hFF.
REQ-035 load_len=2 with ld_valid gaps of 5 cycles between bytes -> busy held throughout, only 2 writes, done once.
REQ-036 CLB pulsed low after 1 of 4 bytes -> immediate IDLE, run=0; a new 4-byte load restores run=1 with the new data.
REQ-037 With PROG_MEM_CHECKSUM_EN defined, bytes 8'hF0,8'h0F,8'hAA -> chk=8'h55 at done.
